// File: rtl/alu.sv
// 32-bit RV32I integer ALU: combinational result from (op, lhs, rhs),
// forced to zero while the registered synchronous reset flag is set.
module alu (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic [31:0] lhs,
  input  logic [31:0] rhs,
  input  logic [4:0]  op,
  output logic [31:0] res
);

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_SLL  = 5'd3;
  localparam logic [4:0] OP_SLT  = 5'd4;
  localparam logic [4:0] OP_SLTU = 5'd5;
  localparam logic [4:0] OP_XOR  = 5'd6;
  localparam logic [4:0] OP_SRL  = 5'd7;
  localparam logic [4:0] OP_SRA  = 5'd8;
  localparam logic [4:0] OP_OR   = 5'd9;
  localparam logic [4:0] OP_AND  = 5'd10;
  localparam logic [4:0] OP_EQ   = 5'd11;
  localparam logic [4:0] OP_NEQ  = 5'd12;
  localparam logic [4:0] OP_LT   = 5'd13;
  localparam logic [4:0] OP_GE   = 5'd14;
  localparam logic [4:0] OP_LTU  = 5'd15;
  localparam logic [4:0] OP_GEU  = 5'd16;

  logic        rst_q;
  logic [4:0]  shamt;
  logic        lt_s;
  logic        lt_u;
  logic        eq;
  logic [31:0] calc;

  always_ff @(posedge CLK) begin
    rst_q <= RST_X;
  end

  // Shared comparators feed both the set-less-than and branch ops.
  assign shamt = rhs[4:0];
  assign lt_s  = $signed(lhs) < $signed(rhs);
  assign lt_u  = lhs < rhs;
  assign eq    = lhs == rhs;

  always_comb begin
    calc = 32'h0;
    case (op)
      OP_NOP:  calc = 32'h0;
      OP_ADD:  calc = lhs + rhs;
      OP_SUB:  calc = lhs - rhs;
      OP_SLL:  calc = lhs << shamt;
      OP_SLT:  calc = {31'b0, lt_s};
      OP_SLTU: calc = {31'b0, lt_u};
      OP_XOR:  calc = lhs ^ rhs;
      OP_SRL:  calc = lhs >> shamt;
      OP_SRA:  calc = $unsigned($signed(lhs) >>> shamt);
      OP_OR:   calc = lhs | rhs;
      OP_AND:  calc = lhs & rhs;
      OP_EQ:   calc = {31'b0, eq};
      OP_NEQ:  calc = {31'b0, !eq};
      OP_LT:   calc = {31'b0, lt_s};
      OP_GE:   calc = {31'b0, !lt_s};
      OP_LTU:  calc = {31'b0, lt_u};
      OP_GEU:  calc = {31'b0, !lt_u};
      default: calc = 32'h0;
    endcase
  end

  assign res = rst_q ? 32'h0 : calc;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed boundary scenarios plus randomized
// operations scored against an arithmetic reference model.
module tb_alu;

  logic        CLK;
  logic        RST_X;
  logic [31:0] lhs;
  logic [31:0] rhs;
  logic [4:0]  op;
  logic [31:0] res;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  alu dut (
    .CLK  (CLK),
    .RST_X(RST_X),
    .lhs  (lhs),
    .rhs  (rhs),
    .op   (op),
    .res  (res)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: results from the op table using plain integer arithmetic.
  function automatic logic [31:0] ref_alu(input logic [4:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub, sh;
    logic [63:0] wide;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    sh = ub % 32;
    case (o)
      5'd1:  wide = ua + ub;
      5'd2:  wide = ua - ub;
      5'd3:  wide = ua * (64'd1 << sh);
      5'd4:  wide = (sa < sb) ? 1 : 0;
      5'd5:  wide = (ua < ub) ? 1 : 0;
      5'd6:  wide = {32'h0, a ^ b};
      5'd7:  wide = ua / (64'd1 << sh);
      5'd8:  wide = $unsigned(sa >>> sh);
      5'd9:  wide = {32'h0, a | b};
      5'd10: wide = {32'h0, a & b};
      5'd11: wide = (ua == ub) ? 1 : 0;
      5'd12: wide = (ua != ub) ? 1 : 0;
      5'd13: wide = (sa < sb) ? 1 : 0;
      5'd14: wide = (sa >= sb) ? 1 : 0;
      5'd15: wide = (ua < ub) ? 1 : 0;
      5'd16: wide = (ua >= ub) ? 1 : 0;
      default: wide = 0;
    endcase
    return wide[31:0];
  endfunction

  task automatic drive(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge CLK);
    op  = o;
    lhs = a;
    rhs = b;
    #2;
  endtask

  task automatic test_reset();
    RST_X = 1'b1;
    op = 5'd1; lhs = 32'd5; rhs = 32'd7;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (res !== 32'h0) begin
      $display("FAIL reset_hold: res=%h expected=%h", res, 32'h0);
      errors++;
    end
    @(negedge CLK);
    RST_X = 1'b0;
    #2;
    checks++;
    if (res !== 32'h0) begin
      $display("FAIL reset_before_release_edge: res=%h expected=%h", res, 32'h0);
      errors++;
    end
    @(posedge CLK);
    #1;
    checks++;
    if (res !== 32'd12) begin
      $display("FAIL reset_release: res=%h expected=%h", res, 32'd12);
      errors++;
    end
  endtask

  task automatic test_directed();
    logic [4:0]  ops[30];
    logic [31:0] as[30];
    logic [31:0] bs[30];
    logic [31:0] ex[30];
    ops = '{5'd1, 5'd2, 5'd2, 5'd3, 5'd7, 5'd8, 5'd8,
            5'd4, 5'd5, 5'd13, 5'd14, 5'd15, 5'd16, 5'd14, 5'd16,
            5'd10, 5'd9, 5'd6, 5'd11, 5'd12,
            5'd0, 5'd17, 5'd31, 5'd3, 5'd7, 5'd11, 5'd12, 5'd4, 5'd5, 5'd8};
    as  = '{32'hFFFFFFFF, 32'h0, 32'd10, 32'h80000001, 32'h80000001, 32'h80000001, 32'h80000001,
            32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'h1234, 32'h1234,
            32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
            32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h1, 32'h80000000, 32'h55, 32'h55,
            32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000};
    bs  = '{32'h1, 32'h1, 32'd3, 32'd33, 32'd4, 32'd4, 32'd0,
            32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1,
            32'h1234, 32'h1234,
            32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0,
            32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55, 32'h55,
            32'h80000000, 32'h80000000, 32'h0000001F};
    ex  = '{32'h0, 32'hFFFFFFFF, 32'd7, 32'h00000002, 32'h08000000, 32'hF8000000, 32'h80000001,
            32'h1, 32'h0, 32'h1, 32'h0, 32'h0, 32'h1,
            32'h1, 32'h1,
            32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00, 32'h0, 32'h1,
            32'h0, 32'h0, 32'h0, 32'h80000000, 32'h1, 32'h1, 32'h0,
            32'h0, 32'h1, 32'hFFFFFFFF};
    for (int i = 0; i < 30; i++) begin
      drive(ops[i], as[i], bs[i]);
      checks++;
      if (res !== ex[i]) begin
        $display("FAIL directed_%0d op=%0d lhs=%h rhs=%h: res=%h expected=%h",
                 i, ops[i], as[i], bs[i], res, ex[i]);
        errors++;
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, exp_v;
    logic [4:0]  o;
    for (int i = 0; i < 400; i++) begin
      o = 5'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: a = 32'h80000000;
        1: a = 32'hFFFFFFFF;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 4) == 0) ? a : $urandom;
      exp_q.push_back(ref_alu(o, a, b));
      drive(o, a, b);
      exp_v = exp_q.pop_front();
      checks++;
      if (res !== exp_v) begin
        $display("FAIL random_%0d op=%0d lhs=%h rhs=%h: res=%h expected=%h",
                 i, o, a, b, res, exp_v);
        errors++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(5'd9, 32'hF0F0F0F0, 32'h0FF00FF0);
    checks++;
    if (res !== 32'hFFF0FFF0) begin
      $display("FAIL midstream_pre: res=%h expected=%h", res, 32'hFFF0FFF0);
      errors++;
    end
    RST_X = 1'b1;
    #1;
    checks++;
    if (res !== 32'hFFF0FFF0) begin
      $display("FAIL midstream_before_edge: res=%h expected=%h", res, 32'hFFF0FFF0);
      errors++;
    end
    @(posedge CLK);
    #1;
    checks++;
    if (res !== 32'h0) begin
      $display("FAIL midstream_after_edge: res=%h expected=%h", res, 32'h0);
      errors++;
    end
    drive(5'd1, 32'h1, 32'h2);
    checks++;
    if (res !== 32'h0) begin
      $display("FAIL midstream_held: res=%h expected=%h", res, 32'h0);
      errors++;
    end
    @(negedge CLK);
    RST_X = 1'b0;
    @(posedge CLK);
    #1;
    checks++;
    if (res !== 32'h3) begin
      $display("FAIL midstream_release: res=%h expected=%h", res, 32'h3);
      errors++;
    end
  endtask

  initial begin
    RST_X = 1'b1;
    op = 5'd0;
    lhs = 32'h0;
    rhs = 32'h0;
    test_reset();
    test_directed();
    test_random();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
